// File: rtl/stream_filter_3x3.sv
// 3x3 neighbourhood filter over a raster-order frame: two line buffers feed a
// sliding window, and one registered arithmetic stage produces gauss/max/min/laplacian.
module stream_filter_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 5,
  parameter int IMG_H      = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [1:0]            MODE,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  FRAME_DONE
);
  // Handshake: IN_VALID=1 means IN_DATA is consumed at that rising edge; there is
  // no ready. OUT_VALID=1 marks one result for exactly one cycle.
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_WIDTH + 4;
  localparam int LW = DATA_WIDTH + 5;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] lb2 [IMG_W];
  logic [DATA_WIDTH-1:0] win [3][3];
  logic                  win_valid;
  logic                  win_last;
  logic [1:0]            frame_mode;
  logic [1:0]            win_mode;
  logic [1:0]            cur_mode;
  logic                  first_pix;
  logic                  last_col;
  logic                  last_row;

  assign first_pix = (row == '0) && (col == '0);
  assign last_col  = (col == CW'(IMG_W - 1));
  assign last_row  = (row == RW'(IMG_H - 1));
  assign cur_mode  = first_pix ? MODE : frame_mode;

  // Mode travels with each window so frame n drains in its own mode while
  // frame n+1 has already sampled a new one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_mode <= 2'b00;
      win_mode   <= 2'b00;
    end else begin
      win_valid <= IN_VALID && (row >= RW'(2)) && (col >= CW'(2));
      if (IN_VALID) begin
        win_last   <= last_row && last_col;
        win_mode   <= cur_mode;
        frame_mode <= cur_mode;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Pixel storage needs no reset: the counters decide when a window is real.
  always_ff @(posedge CLK) begin
    if (IN_VALID && !RESET) begin
      lb2[col] <= lb1[col];
      lb1[col] <= IN_DATA;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb2[col];
      win[1][2] <= lb1[col];
      win[2][2] <= IN_DATA;
    end
  end

  logic [GW-1:0]         corners, edges, gsum;
  logic [DATA_WIDTH-1:0] gauss_out;
  logic [3:0]            unused_frac;
  logic [LW-1:0]         c8, nsum, lap, lap_abs;
  logic [DATA_WIDTH-1:0] lap_out, mx, mn, result;

  always_comb begin
    corners = GW'(win[0][0]) + GW'(win[0][2]) + GW'(win[2][0]) + GW'(win[2][2]);
    edges   = GW'(win[0][1]) + GW'(win[1][0]) + GW'(win[1][2]) + GW'(win[2][1]);
    gsum    = corners + (edges << 1) + (GW'(win[1][1]) << 2);
    {gauss_out, unused_frac} = gsum;

    nsum    = LW'(corners) + LW'(edges);
    c8      = LW'(win[1][1]) << 3;
    lap     = c8 - nsum;
    lap_abs = lap[LW-1] ? -lap : lap;
    if (lap_abs > LW'({DATA_WIDTH{1'b1}})) lap_out = '1;
    else                                   lap_out = lap_abs[DATA_WIDTH-1:0];

    mx = win[0][0];
    mn = win[0][0];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (win[i][j] > mx) mx = win[i][j];
        if (win[i][j] < mn) mn = win[i][j];
      end
    end

    case (win_mode)
      2'b00:   result = gauss_out;
      2'b01:   result = mx;
      2'b10:   result = mn;
      default: result = lap_out;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID  <= 1'b0;
      OUT_DATA   <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      OUT_VALID  <= win_valid;
      FRAME_DONE <= win_valid && win_last;
      if (win_valid) OUT_DATA <= result;
    end
  end
endmodule

// File: tb/tb_stream_filter_3x3.sv
// Directed bench for stream_filter_3x3 (5x5 frames, 8-bit pixels): a monitor
// records every output pulse with its cycle, and each test compares against hand values.
module tb_stream_filter_3x3;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic [1:0] MODE;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       FRAME_DONE;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int stray_fd = 0;
  logic [7:0] got_d[$];
  int         got_c[$];
  logic       got_f[$];
  int         exp_c[$];
  logic [7:0] exp_q[$];

  stream_filter_3x3 #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .MODE(MODE),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Output pulse k registered at edge e is sampled here with cyc == e.
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      got_d.push_back(OUT_DATA);
      got_c.push_back(cyc);
      got_f.push_back(FRAME_DONE);
    end
    if (FRAME_DONE === 1'b1 && OUT_VALID !== 1'b1) stray_fd++;
  end

  task automatic drive(input logic v, input logic [7:0] d);
    IN_VALID = v;
    IN_DATA  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom_range(0, 255)));
  endtask

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (r == 2 && c == 2) ? 8'd16 : 8'd0;
      2:       return 8'(5 * r + c);
      3:       return (r == 2 && c == 2) ? 8'd255 : 8'd0;
      default: return 8'd200;
    endcase
  endfunction

  // A completing pixel accepted at edge k must show up sampled with cyc == k+1.
  task automatic send_frame(input int pat, input bit gap, input logic [1:0] mode_a,
                            input logic [1:0] mode_b, input int sw);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        MODE = (r * 5 + c >= sw) ? mode_b : mode_a;
        drive(1'b1, pix(pat, r, c));
        if (r >= 2 && c >= 2) exp_c.push_back(cyc + 1);
        if (gap) idle(1);
      end
    end
  endtask

  task automatic clear_all();
    got_d.delete(); got_c.delete(); got_f.delete(); exp_c.delete(); exp_q.delete();
    stray_fd = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; MODE = 2'b00;
    drive(1'b1, 8'd50);
    drive(1'b1, 8'd60);
    drive(1'b1, 8'd70);
    total++; if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid got %b want 0", OUT_VALID); else passed++;
    total++; if (OUT_DATA !== 8'd0) $display("FAIL reset_out_data got %0d want 0", OUT_DATA); else passed++;
    total++; if (FRAME_DONE !== 1'b0) $display("FAIL reset_frame_done got %b want 0", FRAME_DONE); else passed++;
    RESET = 1'b0;
    idle(2);
  endtask

  task automatic test_gauss_const();
    clear_all();
    send_frame(0, 1'b0, 2'b00, 2'b00, 0);
    idle(4);
    exp_q = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    total++; if (got_d.size() != 9) $display("FAIL gauss_const_count got %0d want 9", got_d.size()); else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== exp_q[i]) $display("FAIL gauss_const_data[%0d] got %0d want %0d", i, (i < got_d.size()) ? got_d[i] : 8'd0, exp_q[i]);
      else passed++;
      total++;
      if (i >= got_c.size() || got_c[i] != exp_c[i]) $display("FAIL gauss_const_cycle[%0d] got %0d want %0d", i, (i < got_c.size()) ? got_c[i] : -1, exp_c[i]);
      else passed++;
      total++;
      if (i >= got_f.size() || got_f[i] !== (i == 8)) $display("FAIL gauss_const_fd[%0d] got %b want %b", i, (i < got_f.size()) ? got_f[i] : 1'bx, (i == 8));
      else passed++;
    end
    total++; if (stray_fd != 0) $display("FAIL gauss_const_stray_fd got %0d want 0", stray_fd); else passed++;
  endtask

  task automatic test_gauss_impulse();
    clear_all();
    send_frame(1, 1'b0, 2'b00, 2'b00, 0);
    idle(4);
    exp_q = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
    total++; if (got_d.size() != 9) $display("FAIL gauss_imp_count got %0d want 9", got_d.size()); else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== exp_q[i]) $display("FAIL gauss_imp_data[%0d] got %0d want %0d", i, (i < got_d.size()) ? got_d[i] : 8'd0, exp_q[i]);
      else passed++;
    end
    total++; if (OUT_DATA !== 8'd1) $display("FAIL gauss_imp_hold got %0d want 1", OUT_DATA); else passed++;
  endtask

  task automatic test_max_min();
    clear_all();
    send_frame(2, 1'b0, 2'b01, 2'b01, 0);
    idle(3);
    send_frame(2, 1'b0, 2'b10, 2'b10, 0);
    idle(4);
    exp_q = '{8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24,
              8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    total++; if (got_d.size() != 18) $display("FAIL max_min_count got %0d want 18", got_d.size()); else passed++;
    for (int i = 0; i < 18; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== exp_q[i]) $display("FAIL max_min_data[%0d] got %0d want %0d", i, (i < got_d.size()) ? got_d[i] : 8'd0, exp_q[i]);
      else passed++;
      total++;
      if (i >= got_f.size() || got_f[i] !== ((i % 9) == 8)) $display("FAIL max_min_fd[%0d] got %b want %b", i, (i < got_f.size()) ? got_f[i] : 1'bx, ((i % 9) == 8));
      else passed++;
    end
  endtask

  task automatic test_laplacian();
    clear_all();
    send_frame(3, 1'b0, 2'b11, 2'b11, 0);
    idle(4);
    total++; if (got_d.size() != 9) $display("FAIL lap_count got %0d want 9", got_d.size()); else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== 8'd255) $display("FAIL lap_data[%0d] got %0d want 255", i, (i < got_d.size()) ? got_d[i] : 8'd0);
      else passed++;
    end
  endtask

  task automatic test_gaps();
    clear_all();
    send_frame(0, 1'b1, 2'b00, 2'b00, 0);
    idle(4);
    total++; if (got_d.size() != 9) $display("FAIL gaps_count got %0d want 9", got_d.size()); else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== 8'd100) $display("FAIL gaps_data[%0d] got %0d want 100", i, (i < got_d.size()) ? got_d[i] : 8'd0);
      else passed++;
      total++;
      if (i >= got_c.size() || got_c[i] != exp_c[i]) $display("FAIL gaps_cycle[%0d] got %0d want %0d", i, (i < got_c.size()) ? got_c[i] : -1, exp_c[i]);
      else passed++;
    end
    total++; if (stray_fd != 0) $display("FAIL gaps_stray_fd got %0d want 0", stray_fd); else passed++;
  endtask

  // 13 pixels leave the (1,1) window in flight; RESET with IN_VALID high must drop it
  // and discard the pixel. Then two back-to-back frames; MODE goes to max mid-frame 1.
  task automatic test_back_to_back();
    clear_all();
    MODE = 2'b00;
    for (int i = 0; i < 13; i++) drive(1'b1, 8'd200);
    RESET = 1'b1;
    drive(1'b1, 8'd77);
    RESET = 1'b0;
    total++; if (OUT_VALID !== 1'b0) $display("FAIL reset_drop_valid got %b want 0", OUT_VALID); else passed++;
    idle(1);
    total++; if (got_d.size() != 0) $display("FAIL reset_drop_count got %0d want 0", got_d.size()); else passed++;
    send_frame(1, 1'b0, 2'b00, 2'b01, 12);
    send_frame(2, 1'b0, 2'b01, 2'b01, 0);
    idle(4);
    exp_q = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1,
              8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24};
    total++; if (got_d.size() != 18) $display("FAIL b2b_count got %0d want 18", got_d.size()); else passed++;
    for (int i = 0; i < 18; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got %0d want %0d", i, (i < got_d.size()) ? got_d[i] : 8'd0, exp_q[i]);
      else passed++;
      total++;
      if (i >= got_c.size() || got_c[i] != exp_c[i]) $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, (i < got_c.size()) ? got_c[i] : -1, exp_c[i]);
      else passed++;
      total++;
      if (i >= got_f.size() || got_f[i] !== ((i % 9) == 8)) $display("FAIL b2b_fd[%0d] got %b want %b", i, (i < got_f.size()) ? got_f[i] : 1'bx, ((i % 9) == 8));
      else passed++;
    end
    total++; if (stray_fd != 0) $display("FAIL b2b_stray_fd got %0d want 0", stray_fd); else passed++;
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = 8'd0; MODE = 2'b00;
    test_reset();
    test_gauss_const();
    test_gauss_impulse();
    test_max_min();
    test_laplacian();
    test_gaps();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
